// File: rtl/id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : id_ex_stage                                                  |
// | Description : ID->EX pipeline register with MEM/WB operand forwarding,    |
// |               load-use hazard detection and ALU operand selection.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_alusrc_a,
  input  logic              id_alusrc_b,
  input  logic [3:0]        id_aluc,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              ex_hold,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [3:0]        ex_aluc,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  // EX slot contents
  logic              r_valid;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_shamt;
  logic              r_alusrc_a;
  logic              r_alusrc_b;
  logic [3:0]        r_aluc;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  logic              w_load_use;
  logic              w_bubble;
  logic [DATA_W-1:0] w_fwd_rs;
  logic [DATA_W-1:0] w_fwd_rt;

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    w_load_use = id_valid & r_valid & r_mem_read & (r_rd != '0) &
                 ((id_use_rs & (id_rs == r_rd)) | (id_use_rt & (id_rt == r_rd)));
    id_stall   = w_load_use | ex_hold;
    // Flush always kills; a load-use bubble only when EX is free to advance
    w_bubble   = flush | (~ex_hold & w_load_use);
  end

  // Per-operand forwarding: the younger EX/MEM result beats MEM/WB; $0 is never forwarded
  always_comb begin
    w_fwd_rs = r_rs_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rs))
      w_fwd_rs = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rs))
      w_fwd_rs = wb_result;

    w_fwd_rt = r_rt_data;
    if (mem_reg_write && (mem_rd != '0) && (mem_rd == r_rt))
      w_fwd_rt = mem_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == r_rt))
      w_fwd_rt = wb_result;
  end

  // EX register: reset/bubble clears, hold refreshes operand data only, else load from ID
  always_ff @(posedge clk) begin
    if (!rst_n || w_bubble) begin
      r_valid      <= 1'b0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_shamt      <= '0;
      r_alusrc_a   <= 1'b0;
      r_alusrc_b   <= 1'b0;
      r_aluc       <= '0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (ex_hold) begin
      // Capture forwarded values so a source retiring during the hold is not lost
      r_rs_data <= w_fwd_rs;
      r_rt_data <= w_fwd_rt;
    end else begin
      r_valid      <= id_valid;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_rd         <= id_rd;
      r_rs_data    <= id_rs_data;
      r_rt_data    <= id_rt_data;
      r_imm        <= id_imm;
      r_shamt      <= id_shamt;
      r_alusrc_a   <= id_alusrc_a;
      r_alusrc_b   <= id_alusrc_b;
      r_aluc       <= id_aluc;
      // An empty ID slot must never produce side effects downstream
      r_reg_write  <= id_reg_write  & id_valid;
      r_mem_read   <= id_mem_read   & id_valid;
      r_mem_write  <= id_mem_write  & id_valid;
      r_mem_to_reg <= id_mem_to_reg & id_valid;
    end
  end

  // ALU operand select; constant shifts take the amount from shamt on port a
  always_comb begin
    ex_a          = r_alusrc_a ? {{(DATA_W-5){1'b0}}, r_shamt} : w_fwd_rs;
    ex_b          = r_alusrc_b ? r_imm : w_fwd_rt;
    ex_store_data = w_fwd_rt;
  end

  assign ex_valid      = r_valid;
  assign ex_aluc       = r_aluc;
  assign ex_rd         = r_rd;
  assign ex_reg_write  = r_reg_write;
  assign ex_mem_read   = r_mem_read;
  assign ex_mem_write  = r_mem_write;
  assign ex_mem_to_reg = r_mem_to_reg;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_id_ex_stage                                               |
// | Description : Self-checking bench for id_ex_stage: directed scenarios with |
// |               literal expectations plus randomized traffic vs a model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_rs, id_use_rt;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_alusrc_a, id_alusrc_b;
  logic [3:0]  id_aluc;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush, ex_hold;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        id_stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_aluc;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_alusrc_a(id_alusrc_a),
    .id_alusrc_b(id_alusrc_b), .id_aluc(id_aluc), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .ex_hold(ex_hold),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
    .id_stall(id_stall), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_aluc(ex_aluc), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: the instruction sitting in EX ----------------
  typedef struct packed {
    bit        valid;
    bit [4:0]  rs, rt, rd, shamt;
    bit [31:0] rsd, rtd, imm;
    bit        asa, asb;
    bit [3:0]  aluc;
    bit        rw, mr, mw, m2r;
  } ex_t;

  ex_t m;
  bit  model_on = 0;

  // Value a source register really holds right now, seen through the bypass network
  function automatic bit [31:0] reg_value(input bit [4:0] src, input bit [31:0] stale);
    if (src == 0) return stale;
    if (mem_reg_write && mem_rd == src) return mem_result;
    if (wb_reg_write && wb_rd == src) return wb_result;
    return stale;
  endfunction

  function automatic bit hazard();
    return id_valid && m.valid && m.mr && m.rd != 0 &&
           ((id_use_rs && id_rs == m.rd) || (id_use_rt && id_rt == m.rd));
  endfunction

  always @(posedge clk) begin
    model_on = 1;
    if (!rst_n || flush || (!ex_hold && hazard())) begin
      m = '0;
    end else if (ex_hold) begin
      m.rsd = reg_value(m.rs, m.rsd);
      m.rtd = reg_value(m.rt, m.rtd);
    end else begin
      m.valid = id_valid;   m.rs = id_rs;     m.rt = id_rt;   m.rd = id_rd;
      m.rsd = id_rs_data;   m.rtd = id_rt_data; m.imm = id_imm; m.shamt = id_shamt;
      m.asa = id_alusrc_a;  m.asb = id_alusrc_b; m.aluc = id_aluc;
      m.rw = id_reg_write & id_valid;   m.mr  = id_mem_read & id_valid;
      m.mw = id_mem_write & id_valid;   m.m2r = id_mem_to_reg & id_valid;
    end
  end

  // Compare process: every negedge once the model has seen a clock
  always @(negedge clk) begin
    if (model_on) begin
      chk("id_stall", {31'b0, id_stall}, {31'b0, hazard() || ex_hold});
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
      chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, m.rw});
      chk("ex_mem_write", {31'b0, ex_mem_write}, {31'b0, m.mw});
      if (m.valid) begin
        chk("ex_a", ex_a, m.asa ? {27'b0, m.shamt} : reg_value(m.rs, m.rsd));
        chk("ex_b", ex_b, m.asb ? m.imm : reg_value(m.rt, m.rtd));
        chk("ex_store_data", ex_store_data, reg_value(m.rt, m.rtd));
        chk("ex_aluc", {28'b0, ex_aluc}, {28'b0, m.aluc});
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, m.rd});
        chk("ex_mem_read", {31'b0, ex_mem_read}, {31'b0, m.mr});
        chk("ex_mem_to_reg", {31'b0, ex_mem_to_reg}, {31'b0, m.m2r});
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_rd = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_alusrc_a = 0; id_alusrc_b = 0; id_aluc = 0;
    id_reg_write = 0; id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
    flush = 0; ex_hold = 0;
    mem_reg_write = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic instr(input bit [4:0] rs, input bit urs, input bit [31:0] rsd,
                       input bit [4:0] rt, input bit urt, input bit [31:0] rtd,
                       input bit [4:0] rd, input bit [31:0] imm, input bit [4:0] sh,
                       input bit asa, input bit asb, input bit [3:0] aluc,
                       input bit rw, input bit mr, input bit mw, input bit m2r);
    id_valid = 1; id_rs = rs; id_use_rs = urs; id_rs_data = rsd;
    id_rt = rt; id_use_rt = urt; id_rt_data = rtd; id_rd = rd; id_imm = imm;
    id_shamt = sh; id_alusrc_a = asa; id_alusrc_b = asb; id_aluc = aluc;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_mem_to_reg = m2r;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    // 1: reset dominates a valid instruction in ID
    instr(5'd1, 1, 32'h5, 5'd2, 1, 32'h7, 5'd3, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'b0, ex_valid}, 0);
      chk("rst_reg_write", {31'b0, ex_reg_write}, 0);
      chk("rst_a", ex_a, 0);
      chk("rst_b", ex_b, 0);
    end
    next_cycle();
    rst_n = 1;

    // 2: add $3,$1,$2
    next_cycle(); idle();
    @(negedge clk);
    chk("add_a", ex_a, 32'h5);
    chk("add_b", ex_b, 32'h7);
    chk("add_aluc", {28'b0, ex_aluc}, 32'h2);
    chk("add_rd", {27'b0, ex_rd}, 32'd3);

    // 3: MEM beats WB on $1; writes to $0 are not forwarded; WB alone forwards
    next_cycle();
    instr(5'd1, 1, 32'h11, 5'd2, 1, 32'h22, 5'd3, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0);
    next_cycle(); idle();
    mem_reg_write = 1; mem_rd = 1; mem_result = 32'hAA;
    wb_reg_write = 1;  wb_rd = 1;  wb_result = 32'hBB;
    @(negedge clk);
    chk("fwd_mem_over_wb", ex_a, 32'hAA);
    #1 mem_rd = 0; wb_rd = 0;
    #1 chk("no_fwd_r0", ex_a, 32'h11);
    #1 mem_reg_write = 0; wb_rd = 1;
    #1 chk("fwd_wb", ex_a, 32'hBB);

    // 4: lw $4 then add using $4
    next_cycle(); idle();
    instr(5'd0, 0, 0, 5'd0, 0, 0, 5'd4, 0, 0, 0, 1, 4'h2, 1, 1, 0, 1);
    next_cycle();
    instr(5'd4, 1, 32'hDEAD, 5'd0, 0, 0, 5'd5, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0);
    @(negedge clk);
    chk("lu_stall", {31'b0, id_stall}, 1);
    next_cycle();
    @(negedge clk);
    chk("lu_bubble_valid", {31'b0, ex_valid}, 0);
    chk("lu_bubble_rw", {31'b0, ex_reg_write}, 0);
    chk("lu_stall_done", {31'b0, id_stall}, 0);
    next_cycle(); idle();
    wb_reg_write = 1; wb_rd = 4; wb_result = 32'h1234;
    @(negedge clk);
    chk("lu_fwd_a", ex_a, 32'h1234);

    // 5: hold while MEM/WB forward of $2 retires
    next_cycle(); idle();
    instr(5'd0, 0, 0, 5'd2, 1, 32'h0, 5'd7, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0);
    next_cycle();
    instr(5'd1, 1, 32'h9, 5'd3, 1, 0, 5'd8, 0, 0, 0, 0, 4'h2, 1, 0, 0, 0);
    ex_hold = 1; wb_reg_write = 1; wb_rd = 2; wb_result = 32'h55;
    @(negedge clk);
    chk("hold_stall", {31'b0, id_stall}, 1);
    next_cycle(); wb_reg_write = 0;
    next_cycle();
    next_cycle(); ex_hold = 0;
    @(negedge clk);
    chk("hold_keep_b", ex_b, 32'h55);
    chk("hold_keep_rd", {27'b0, ex_rd}, 32'd7);

    // 6: flush with hold and load-use pending
    next_cycle(); idle();
    instr(5'd0, 0, 0, 5'd0, 0, 0, 5'd6, 0, 0, 0, 1, 4'h2, 1, 1, 0, 1);
    next_cycle();
    instr(5'd6, 1, 0, 5'd2, 1, 0, 5'd0, 32'h4, 0, 0, 1, 4'h2, 0, 0, 1, 0);
    flush = 1; ex_hold = 1;
    @(negedge clk);
    chk("flush_stall", {31'b0, id_stall}, 1);
    next_cycle(); idle();
    @(negedge clk);
    chk("flush_valid", {31'b0, ex_valid}, 0);
    chk("flush_mem_write", {31'b0, ex_mem_write}, 0);

    // 7: sll $5,$6,3 and sw with forwarded store data
    next_cycle();
    instr(5'd0, 0, 0, 5'd6, 1, 32'h77, 5'd5, 0, 5'd3, 1, 0, 4'h8, 1, 0, 0, 0);
    next_cycle(); idle();
    mem_reg_write = 1; mem_rd = 6; mem_result = 32'h600;
    @(negedge clk);
    chk("sll_a", ex_a, 32'h3);
    chk("sll_b", ex_b, 32'h600);
    next_cycle(); idle();
    instr(5'd1, 1, 32'h100, 5'd2, 1, 32'h200, 5'd0, 32'h8, 0, 0, 1, 4'h2, 0, 0, 1, 0);
    next_cycle(); idle();
    wb_reg_write = 1; wb_rd = 2; wb_result = 32'h222;
    @(negedge clk);
    chk("sw_b_imm", ex_b, 32'h8);
    chk("sw_store_data", ex_store_data, 32'h222);
    chk("sw_a", ex_a, 32'h100);

    // Randomized traffic over a small register set to provoke hazards and forwards
    for (int c = 0; c < 600; c++) begin
      next_cycle();
      rst_n         = ($urandom_range(0, 99) >= 2);
      flush         = ($urandom_range(0, 99) < 8);
      ex_hold       = ($urandom_range(0, 99) < 15);
      id_valid      = ($urandom_range(0, 99) < 85);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_rd         = 5'($urandom_range(0, 3));
      id_use_rs     = 1'($urandom);
      id_use_rt     = 1'($urandom);
      id_rs_data    = $urandom;
      id_rt_data    = $urandom;
      id_imm        = $urandom;
      id_shamt      = 5'($urandom);
      id_alusrc_a   = ($urandom_range(0, 3) == 0);
      id_alusrc_b   = 1'($urandom);
      id_aluc       = 4'($urandom);
      id_reg_write  = id_valid & 1'($urandom);
      id_mem_read   = id_valid & ($urandom_range(0, 1) == 0);
      id_mem_write  = id_valid & ($urandom_range(0, 3) == 0);
      id_mem_to_reg = id_mem_read;
      mem_reg_write = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_result    = $urandom;
      wb_reg_write  = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 3));
      wb_result     = $urandom;
    end
    next_cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
